// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants for the multicycle MIPS controller.
// Holds the 4-bit FSM state encoding, opcode/funct constants, the internal
// aluop codes and the alucontrol codes, plus the per-state control bundle.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluen marks states that actually use the ALU; alucontrol reads 0 elsewhere.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       iord;
    logic [3:0] irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       aluen;
    aluop_t     aluop;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// mips_multicycle_controller_if: control/status bus between the controller
// and the 8-bit multicycle datapath plus byte memory strobes.
//   status  : op, funct (instr fields), zero (ALU flag)
//   control : memread, memwrite, alusrca, alusrcb, alucontrol, pcsrc, pcen,
//             iord, irwrite, regwrite, regdst, memtoreg
// master = controller side, slave = datapath/memory side.
interface mips_multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       iord;
  logic [3:0] irwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;

  modport master (
    input  op, funct, zero,
    output memread, memwrite, alusrca, alusrcb, alucontrol, pcsrc, pcen,
           iord, irwrite, regwrite, regdst, memtoreg
  );

  modport slave (
    output op, funct, zero,
    input  memread, memwrite, alusrca, alusrcb, alucontrol, pcsrc, pcen,
           iord, irwrite, regwrite, regdst, memtoreg
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational map of aluop (+ funct for R-type) to the
// 3-bit alucontrol code.
//   aluop      in  2  add / sub / funct / reserved (reserved behaves as add)
//   funct      in  6  instr[5:0]
//   alucontrol out 3  ALU operation
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore control FSM for the 8-bit multicycle MIPS.
// Fetches a 32-bit instruction as four bytes, then sequences it through
// execute / memory / writeback.
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high; forces all control outputs to 0
//   bus    master modport of mips_multicycle_controller_if (status in,
//          control out)
// Optional feature: define MIPS_CTRL_ADDI_EN to build the ADDIEX/ADDIWR path;
// without it opcode 001000 is treated as an illegal op (no writeback).
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  mips_multicycle_controller_if.master    bus
);

  state_t     state, next_state;
  ctrl_t      ctrl, ctrl_o;
  logic [2:0] dec_alucontrol;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH1;
    else       state <= next_state;
  end

  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALUOP_ADD;
    next_state = S_FETCH1;
    case (state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.aluen   = 1'b1;
        ctrl.pcen    = 1'b1;
        // one-hot byte lane follows the low two bits of the fetch state
        ctrl.irwrite = 4'b0001 << state[1:0];
        case (state)
          S_FETCH1: next_state = S_FETCH2;
          S_FETCH2: next_state = S_FETCH3;
          S_FETCH3: next_state = S_FETCH4;
          default:  next_state = S_DECODE;
        endcase
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluen   = 1'b1;
        case (bus.op)
          OP_LB, OP_SB: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_J:         next_state = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      next_state = S_ADDIEX;
`endif
          default:      next_state = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluen   = 1'b1;
        next_state   = (bus.op == OP_LB) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        next_state   = S_LBWR;
      end
      S_LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluen   = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
        next_state   = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluen   = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.pcen    = bus.zero;
      end
      S_JEX: begin
        ctrl.pcsrc = 2'b10;
        ctrl.pcen  = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluen   = 1'b1;
        next_state   = S_ADDIWR;
      end
      S_ADDIWR: begin
        ctrl.regwrite = 1'b1;
      end
`endif
      default: next_state = S_FETCH1;
    endcase
  end

  mips_alu_decoder u_alu_decoder (
    .aluop      (ctrl.aluop),
    .funct      (bus.funct),
    .alucontrol (dec_alucontrol)
  );

  // Reset blanks the bus in the same cycle, so no writeback can leak out.
  assign ctrl_o = reset ? '0 : ctrl;

  assign bus.memread    = ctrl_o.memread;
  assign bus.memwrite   = ctrl_o.memwrite;
  assign bus.alusrca    = ctrl_o.alusrca;
  assign bus.alusrcb    = ctrl_o.alusrcb;
  assign bus.alucontrol = ctrl_o.aluen ? dec_alucontrol : '0;
  assign bus.pcsrc      = ctrl_o.pcsrc;
  assign bus.pcen       = ctrl_o.pcen;
  assign bus.iord       = ctrl_o.iord;
  assign bus.irwrite    = ctrl_o.irwrite;
  assign bus.regwrite   = ctrl_o.regwrite;
  assign bus.regdst     = ctrl_o.regdst;
  assign bus.memtoreg   = ctrl_o.memtoreg;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
module tb_mips_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [18:0] exp;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // packed as {memread, memwrite, alusrca, alusrcb, alucontrol, pcsrc, pcen,
  //            iord, irwrite, regwrite, regdst, memtoreg}
  function automatic logic [18:0] e(input logic mr, input logic mw,
                                    input logic asa, input logic [1:0] asb,
                                    input logic [2:0] alu, input logic [1:0] ps,
                                    input logic pe, input logic io,
                                    input logic [3:0] ir, input logic rw,
                                    input logic rd, input logic m2r);
    return {mr, mw, asa, asb, alu, ps, pe, io, ir, rw, rd, m2r};
  endfunction

  function automatic logic [18:0] e_fetch(input int unsigned i);
    logic [3:0] ir;
    ir = 4'b0001 << i;
    return e(1, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, ir, 0, 0, 0);
  endfunction

  logic [18:0] E_RST, E_DEC, E_MA, E_LBRD, E_LBWR, E_SBWR, E_RTWR, E_JEX;
  logic [18:0] E_ADDIEX, E_ADDIWR;

  function automatic logic [18:0] e_rtex(input logic [2:0] alu);
    return e(0, 0, 1, 2'b00, alu, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
  endfunction

  function automatic logic [18:0] e_beq(input logic z);
    return e(0, 0, 1, 2'b00, 3'b110, 2'b01, z, 0, 4'b0000, 0, 0, 0);
  endfunction

  function automatic logic [18:0] observed();
    return {bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb,
            bus.alucontrol, bus.pcsrc, bus.pcen, bus.iord, bus.irwrite,
            bus.regwrite, bus.regdst, bus.memtoreg};
  endfunction

  task automatic push(input string nm, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic z,
                      input logic [18:0] ex);
    vec_t v;
    v.rst = rst; v.op = op; v.funct = fn; v.zero = z; v.exp = ex;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic push_fetch_decode(input string nm, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z);
    for (int unsigned i = 0; i < 4; i++)
      push($sformatf("%s_fetch%0d", nm, i + 1), 0, op, fn, z, e_fetch(i));
    push({nm, "_decode"}, 0, op, fn, z, E_DEC);
  endtask

  // drive inputs, let them settle, compare, then advance one clock
  task automatic apply_check(input string nm, input logic rst,
                             input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic [18:0] ex);
    logic [18:0] got;
    reset = rst; bus.op = op; bus.funct = fn; bus.zero = z;
    #2;
    got = observed();
    n_checks++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, ex);
    end
    @(posedge clk);
    #1;
  endtask

  // counts cycles from the FETCH1 just presented until FETCH1 shows again
  task automatic count_cpi(input string nm, input logic [5:0] op,
                           input logic [5:0] fn, input int exp_n);
    int n;
    reset = 1'b0; bus.op = op; bus.funct = fn; bus.zero = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.irwrite !== 4'b0001 && n < 20);
    n_checks++;
    if (n != exp_n) begin
      n_fail++;
      $display("FAIL cpi_%s: got %0d cycles expected %0d", nm, n, exp_n);
    end
  endtask

  initial begin
    E_RST    = '0;
    E_DEC    = e(0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
    E_MA     = e(0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
    E_LBRD   = e(1, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 4'b0000, 0, 0, 0);
    E_LBWR   = e(0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 4'b0000, 1, 0, 1);
    E_SBWR   = e(0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1, 4'b0000, 0, 0, 0);
    E_RTWR   = e(0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 4'b0000, 1, 1, 0);
    E_JEX    = e(0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0, 4'b0000, 0, 0, 0);
    E_ADDIEX = e(0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 4'b0000, 0, 0, 0);
    E_ADDIWR = e(0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 4'b0000, 1, 0, 0);

    push("reset_c1", 1, 6'b100000, 6'd0, 0, E_RST);
    push("reset_c2", 1, 6'b100000, 6'd0, 1, E_RST);

    push_fetch_decode("lb", 6'b100000, 6'd0, 0);
    push("lb_memadr", 0, 6'b100000, 6'd0, 0, E_MA);
    push("lb_rd",     0, 6'b100000, 6'd0, 0, E_LBRD);
    push("lb_wr",     0, 6'b100000, 6'd0, 0, E_LBWR);

    push_fetch_decode("sb", 6'b101000, 6'd0, 0);
    push("sb_memadr", 0, 6'b101000, 6'd0, 0, E_MA);
    push("sb_wr",     0, 6'b101000, 6'd0, 0, E_SBWR);

    push_fetch_decode("slt", 6'b000000, 6'b101010, 0);
    push("slt_ex", 0, 6'b000000, 6'b101010, 0, e_rtex(3'b111));
    push("slt_wr", 0, 6'b000000, 6'b101010, 0, E_RTWR);

    push_fetch_decode("sub", 6'b000000, 6'b100010, 0);
    push("sub_ex", 0, 6'b000000, 6'b100010, 0, e_rtex(3'b110));
    push("sub_wr", 0, 6'b000000, 6'b100010, 0, E_RTWR);

    push_fetch_decode("and", 6'b000000, 6'b100100, 0);
    push("and_ex", 0, 6'b000000, 6'b100100, 0, e_rtex(3'b000));
    push("and_wr", 0, 6'b000000, 6'b100100, 0, E_RTWR);

    push_fetch_decode("or", 6'b000000, 6'b100101, 0);
    push("or_ex", 0, 6'b000000, 6'b100101, 0, e_rtex(3'b001));
    push("or_wr", 0, 6'b000000, 6'b100101, 0, E_RTWR);

    push_fetch_decode("badfn", 6'b000000, 6'b000111, 0);
    push("badfn_ex", 0, 6'b000000, 6'b000111, 0, e_rtex(3'b010));
    push("badfn_wr", 0, 6'b000000, 6'b000111, 0, E_RTWR);

    push_fetch_decode("beq_t", 6'b000100, 6'd0, 1);
    push("beq_t_ex", 0, 6'b000100, 6'd0, 1, e_beq(1));

    push_fetch_decode("beq_nt", 6'b000100, 6'd0, 1);
    push("beq_nt_ex", 0, 6'b000100, 6'd0, 0, e_beq(0));

    push_fetch_decode("j", 6'b000010, 6'd0, 1);
    push("j_ex", 0, 6'b000010, 6'd0, 0, E_JEX);

    push_fetch_decode("ill", 6'b111111, 6'd0, 0);

    push_fetch_decode("addi", 6'b001000, 6'd0, 0);
`ifdef MIPS_CTRL_ADDI_EN
    push("addi_ex", 0, 6'b001000, 6'd0, 0, E_ADDIEX);
    push("addi_wr", 0, 6'b001000, 6'd0, 0, E_ADDIWR);
`endif
    push("after_addi_fetch1", 0, 6'b000000, 6'd0, 0, e_fetch(0));

    reset = 1'b1; bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    for (int unsigned i = 0; i < vecs.size(); i++)
      apply_check(names[i], vecs[i].rst, vecs[i].op, vecs[i].funct,
                  vecs[i].zero, vecs[i].exp);

    // reset arriving in LBRD kills the load before its writeback
    apply_check("rl_reset", 1, 6'b100000, 6'd0, 0, E_RST);
    for (int unsigned i = 0; i < 4; i++)
      apply_check($sformatf("rl_fetch%0d", i + 1), 0, 6'b100000, 6'd0, 0,
                  e_fetch(i));
    apply_check("rl_decode", 0, 6'b100000, 6'd0, 0, E_DEC);
    apply_check("rl_memadr", 0, 6'b100000, 6'd0, 0, E_MA);
    apply_check("rl_reset_in_lbrd", 1, 6'b100000, 6'd0, 0, E_RST);
    apply_check("rl_post_fetch1", 0, 6'b100000, 6'd0, 0, e_fetch(0));
    apply_check("rl_post_fetch2", 0, 6'b100000, 6'd0, 0, e_fetch(1));

    // reset arriving in RTYPEWR blanks the register write in that cycle
    apply_check("rw_fetch3", 0, 6'b000000, 6'b100000, 0, e_fetch(2));
    apply_check("rw_fetch4", 0, 6'b000000, 6'b100000, 0, e_fetch(3));
    apply_check("rw_decode", 0, 6'b000000, 6'b100000, 0, E_DEC);
    apply_check("rw_ex",     0, 6'b000000, 6'b100000, 0, e_rtex(3'b010));
    apply_check("rw_reset_in_wr", 1, 6'b000000, 6'b100000, 0, E_RST);
    apply_check("rw_post_fetch1", 0, 6'b000000, 6'b100000, 0, e_fetch(0));

    // re-synchronise to FETCH1, then measure cycles per instruction
    apply_check("cpi_reset", 1, 6'b000000, 6'd0, 0, E_RST);
    count_cpi("lb",   6'b100000, 6'd0, 8);
    count_cpi("sb",   6'b101000, 6'd0, 7);
    count_cpi("rtyp", 6'b000000, 6'b101010, 7);
    count_cpi("beq",  6'b000100, 6'd0, 6);
    count_cpi("j",    6'b000010, 6'd0, 6);
    count_cpi("ill",  6'b111111, 6'd0, 5);
`ifdef MIPS_CTRL_ADDI_EN
    count_cpi("addi", 6'b001000, 6'd0, 7);
`else
    count_cpi("addi", 6'b001000, 6'd0, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // absolute backstop so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
